// File: rtl/io_in_pkg.sv
// Shared types and helpers for the board-input conditioner.
package io_in_pkg;

  localparam int unsigned IO_W = 32;

  typedef enum logic {STABLE0, STABLE1} db_state_e;

  // Counter width needed to hold the values 0..cyc
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return int'($clog2(cyc + 1));
  endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a counter-qualified stable-level FSM.
module debounce_bit
  import io_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= d_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle of agreement clears the count; only an unbroken run toggles the level
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE0: begin
        if (s2_q) begin
          if (cnt_q == CNT_LAST) state_d = STABLE1;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      STABLE1: begin
        if (!s2_q) begin
          if (cnt_q == CNT_LAST) state_d = STABLE0;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = STABLE0;
    endcase
  end

  assign q_o = (state_q == STABLE1);

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces slide switches and push-buttons for the LSU input region.
// Optional IO_PUSH_EDGE_EN adds a one-cycle press pulse output io_push_edge_o.
module io_input_conditioner
  import io_in_pkg::*;
#(
  parameter int unsigned SW_W         = 18,
  parameter int unsigned PUSH_W       = 4,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter bit          PUSH_ACT_LOW = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [SW_W-1:0]   sw_raw_i,
  input  logic [PUSH_W-1:0] push_raw_i,
  output logic [IO_W-1:0]   io_sw_o,
  output logic [IO_W-1:0]   io_push_o
`ifdef IO_PUSH_EDGE_EN
  ,
  output logic [IO_W-1:0]   io_push_edge_o
`endif
);

  logic [SW_W-1:0]   sw_level;
  logic [PUSH_W-1:0] push_in;
  logic [PUSH_W-1:0] push_level;

  // Buttons are normalised to 1 = pressed before entering the synchroniser
  assign push_in = PUSH_ACT_LOW ? ~push_raw_i : push_raw_i;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_bit #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (sw_raw_i[i]),
      .q_o    (sw_level[i])
    );
  end

  for (genvar i = 0; i < PUSH_W; i++) begin : g_push
    debounce_bit #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (push_in[i]),
      .q_o    (push_level[i])
    );
  end

  assign io_sw_o   = IO_W'(sw_level);
  assign io_push_o = IO_W'(push_level);

`ifdef IO_PUSH_EDGE_EN
  logic [PUSH_W-1:0] push_prev_q;
  logic [PUSH_W-1:0] push_edge_q;

  // Pulse lands in the cycle after the debounced level rises
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_prev_q <= '0;
      push_edge_q <= '0;
    end else begin
      push_prev_q <= push_level;
      push_edge_q <= push_level & ~push_prev_q;
    end
  end

  assign io_push_edge_o = IO_W'(push_edge_q);
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYC = 4 (step latency 6 edges).
module tb_io_input_conditioner;

  localparam int unsigned LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] sw_raw;
  logic [3:0]  push_raw;
  logic [31:0] io_sw;
  logic [31:0] io_push;
`ifdef IO_PUSH_EDGE_EN
  logic [31:0] io_push_edge;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_input_conditioner #(
    .SW_W         (18),
    .PUSH_W       (4),
    .DEBOUNCE_CYC (4),
    .PUSH_ACT_LOW (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sw_raw_i   (sw_raw),
    .push_raw_i (push_raw),
    .io_sw_o    (io_sw),
    .io_push_o  (io_push)
`ifdef IO_PUSH_EDGE_EN
    ,
    .io_push_edge_o (io_push_edge)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; leaves time 1 unit after the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    sw_raw   = '0;
    push_raw = 4'hF;
    tick(LAT + 2);
    check("idle_sw", io_sw, 32'h0);
    check("idle_push", io_push, 32'h0);
  endtask

  initial begin
    // 1: reset and first qualification after release
    rst_n    = 1'b0;
    sw_raw   = 18'h3FFFF;
    push_raw = 4'h0;
    tick(4);
    check("rst_sw", io_sw, 32'h0);
    check("rst_push", io_push, 32'h0);
`ifdef IO_PUSH_EDGE_EN
    check("rst_edge", io_push_edge, 32'h0);
`endif
    rst_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      check($sformatf("rel_sw_e%0d", i), io_sw, (i == LAT) ? 32'h0003FFFF : 32'h0);
      check($sformatf("rel_push_e%0d", i), io_push, (i == LAT) ? 32'hF : 32'h0);
    end
    go_idle();

    // 2: clean step on sw[0]
    sw_raw = 18'h00001;
    for (int i = 1; i <= LAT + 1; i++) begin
      tick(1);
      check($sformatf("step_e%0d", i), io_sw, (i >= LAT) ? 32'h1 : 32'h0);
    end
    go_idle();

    // 3: bounce on push[2] (pin active-low)
    push_raw = 4'hB;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check($sformatf("bnc_a%0d", i), io_push, 32'h0);
    end
    push_raw = 4'hF;
    tick(1);
    check("bnc_b", io_push, 32'h0);
    push_raw = 4'hB;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      check($sformatf("bnc_c%0d", i), io_push, (i == LAT) ? 32'h4 : 32'h0);
    end
    go_idle();

    // 4: simultaneous multi-bit transitions
    sw_raw   = 18'h2AAAA;
    push_raw = 4'h5;
    tick(LAT - 1);
    check("sim_sw_pre", io_sw, 32'h0);
    check("sim_push_pre", io_push, 32'h0);
    tick(1);
    check("sim_sw", io_sw, 32'h0002AAAA);
    check("sim_push", io_push, 32'h0000000A);
    go_idle();

    // 5: reset in the middle of qualification on sw[5]
    sw_raw = 18'h00020;
    tick(4);
    check("mid_pre", io_sw, 32'h0);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst", io_sw, 32'h0);
    tick(2);
    check("mid_rst2", io_sw, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      check($sformatf("mid_e%0d", i), io_sw, (i == LAT) ? 32'h20 : 32'h0);
    end
    go_idle();

    // 6: press and release button 1
    push_raw = 4'hD;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick(1);
      check($sformatf("prs_e%0d", i), io_push, (i >= LAT) ? 32'h2 : 32'h0);
`ifdef IO_PUSH_EDGE_EN
      check($sformatf("prs_edge_e%0d", i), io_push_edge, (i == LAT + 1) ? 32'h2 : 32'h0);
`endif
    end
    push_raw = 4'hF;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick(1);
      check($sformatf("rls_e%0d", i), io_push, (i >= LAT) ? 32'h0 : 32'h2);
`ifdef IO_PUSH_EDGE_EN
      check($sformatf("rls_edge_e%0d", i), io_push_edge, 32'h0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
